// File: rtl/softmax_row_collector_pkg.sv
// Shared self-attention definitions: default geometry of the softmax slice and the
// collector state encoding.
package softmax_row_collector_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_COL        = 64;
  localparam int unsigned DEFAULT_TILE_SIZE  = 8;
  localparam int unsigned DEFAULT_NUM_CORES  = 2;
  localparam int unsigned DEFAULT_BLOCK_SIZE = 2;

  localparam int unsigned ROWS       = DEFAULT_NUM_CORES * DEFAULT_BLOCK_SIZE;
  localparam int unsigned NUM_TILES  = DEFAULT_COL / DEFAULT_TILE_SIZE;
  localparam int unsigned TILE_WIDTH = DEFAULT_WIDTH * DEFAULT_TILE_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

endpackage

// File: rtl/softmax_tile_buffer.sv
// One softmax row: NUM_TILES tile registers with a single write port and an
// asynchronous read port. Contents are deliberately not reset.
module softmax_tile_buffer #(
  parameter int unsigned NUM_TILES  = 8,
  parameter int unsigned TILE_WIDTH = 128,
  localparam int unsigned IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [TILE_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [TILE_WIDTH-1:0] rdata
);

  logic [TILE_WIDTH-1:0] mem_q [NUM_TILES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/softmax_row_collector.sv
// Collects per-row softmax output tiles and emits them column by column once every
// row has delivered the tile at the current read index.
module softmax_row_collector
  import softmax_row_collector_pkg::*;
#(
  parameter int unsigned WIDTH              = DEFAULT_WIDTH,
  parameter int unsigned COL                = DEFAULT_COL,
  parameter int unsigned TILE_SIZE          = DEFAULT_TILE_SIZE,
  parameter int unsigned NUM_CORES_A_Qn_KnT = DEFAULT_NUM_CORES,
  parameter int unsigned BLOCK_SIZE         = DEFAULT_BLOCK_SIZE,
  localparam int unsigned ROWS       = NUM_CORES_A_Qn_KnT * BLOCK_SIZE,
  localparam int unsigned NUM_TILES  = COL / TILE_SIZE,
  localparam int unsigned TILE_WIDTH = WIDTH * TILE_SIZE,
  localparam int unsigned IDX_W      = $clog2(NUM_TILES),
  localparam int unsigned CNT_W      = $clog2(NUM_TILES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROWS-1:0]              tile_in_valid,
  input  logic [ROWS*TILE_WIDTH-1:0]   tile_in_data,
  output logic [ROWS-1:0]              tile_in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS*TILE_WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]             out_tile_idx,
  output logic                         out_last,
  output logic                         slice_done,
  output logic                         overflow_err
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [CNT_W-1:0]  wr_cnt_q [ROWS];
  logic              overflow_q;

  logic [ROWS-1:0]   accept;
  logic              col_ready;
  logic              handshake;
  logic              overflow_set;

  always_comb begin
    tile_in_ready = '0;
    accept        = '0;
    col_ready     = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      tile_in_ready[r] = (wr_cnt_q[r] != CNT_W'(NUM_TILES)) && (state_q != S_DONE);
      accept[r]        = tile_in_valid[r] && tile_in_ready[r];
      if (wr_cnt_q[r] <= CNT_W'(rd_idx_q)) begin
        col_ready = 1'b0;
      end
    end
  end

  assign out_valid    = (state_q == S_STREAM) && col_ready;
  assign handshake    = out_valid && out_ready;
  assign out_tile_idx = rd_idx_q;
  assign out_last     = (rd_idx_q == IDX_W'(NUM_TILES - 1));
  assign slice_done   = (state_q == S_DONE);
  assign overflow_err = overflow_q;
  // Tiles offered while the slice is being retired are refused silently.
  assign overflow_set = (|(tile_in_valid & ~tile_in_ready)) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|accept) state_d = S_STREAM;
      S_STREAM: if (handshake && out_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        wr_cnt_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end
      if (state_q == S_DONE) begin
        rd_idx_q <= '0;
        for (int r = 0; r < ROWS; r++) begin
          wr_cnt_q[r] <= '0;
        end
      end else begin
        // The final column leaves rd_idx parked; S_DONE clears it.
        if (handshake && !out_last) begin
          rd_idx_q <= rd_idx_q + IDX_W'(1);
        end
        for (int r = 0; r < ROWS; r++) begin
          if (accept[r]) begin
            wr_cnt_q[r] <= wr_cnt_q[r] + CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    softmax_tile_buffer #(
      .NUM_TILES  (NUM_TILES),
      .TILE_WIDTH (TILE_WIDTH)
    ) u_buf (
      .clk   (clk),
      .we    (accept[r]),
      .waddr (wr_cnt_q[r][IDX_W-1:0]),
      .wdata (tile_in_data[r*TILE_WIDTH +: TILE_WIDTH]),
      .raddr (rd_idx_q),
      .rdata (out_data[r*TILE_WIDTH +: TILE_WIDTH])
    );
  end

endmodule

// File: tb/tb_softmax_row_collector.sv
// Bench for softmax_row_collector: a slice-level model of per-row tile arrival and
// column emission, checked every cycle, plus directed literal checks.
module tb_softmax_row_collector;

  localparam int ROWS = 4;
  localparam int NT   = 8;
  localparam int TW   = 128;
  localparam int DW   = ROWS * TW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] tile_in_valid;
  logic [DW-1:0]   tile_in_data;
  logic [ROWS-1:0] tile_in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_tile_idx;
  logic            out_last;
  logic            slice_done;
  logic            overflow_err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  softmax_row_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tile_in_valid (tile_in_valid),
    .tile_in_data  (tile_in_data),
    .tile_in_ready (tile_in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tile_idx  (out_tile_idx),
    .out_last      (out_last),
    .slice_done    (slice_done),
    .overflow_err  (overflow_err)
  );

  // Element e of tile t of row r in slice sl is 16'h{sl,r,t,e}.
  function automatic logic [TW-1:0] tile_val(input int sl, input int r, input int t);
    logic [TW-1:0] v;
    for (int e = 0; e < 8; e++) v[e*16 +: 16] = {4'(sl), 4'(r), 4'(t), 4'(e)};
    return v;
  endfunction

  function automatic void chk(input string nm, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  // Slice model: tiles received per row, next column to emit, slice phase.
  int            m_cnt [ROWS];
  int            m_rd;
  bit            m_active;
  bit            m_done;
  bit            m_ovf;
  logic [TW-1:0] m_buf [ROWS][NT];

  function automatic bit m_rdy(input int r);
    return (m_cnt[r] < NT) && !m_done;
  endfunction

  function automatic bit m_valid();
    if (!m_active) return 1'b0;
    for (int r = 0; r < ROWS; r++) if (m_cnt[r] <= m_rd) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit hs, was_active, was_done, any_acc;
    bit rdy [ROWS];
    if (rst_n !== 1'b1) begin
      for (int r = 0; r < ROWS; r++) m_cnt[r] = 0;
      m_rd = 0; m_active = 0; m_done = 0; m_ovf = 0;
      return;
    end
    hs = m_valid() && (out_ready === 1'b1);
    was_active = m_active;
    was_done = m_done;
    any_acc = 0;
    for (int r = 0; r < ROWS; r++) rdy[r] = m_rdy(r);
    for (int r = 0; r < ROWS; r++) begin
      if (tile_in_valid[r] === 1'b1) begin
        if (rdy[r]) begin
          m_buf[r][m_cnt[r]] = tile_in_data[r*TW +: TW];
          m_cnt[r]++;
          any_acc = 1;
        end else if (!was_done) begin
          m_ovf = 1;
        end
      end
    end
    if (was_done) begin
      for (int r = 0; r < ROWS; r++) m_cnt[r] = 0;
      m_rd = 0;
      m_done = 0;
    end else begin
      if (hs) begin
        if (m_rd == NT - 1) begin
          m_done = 1;
          m_active = 0;
        end else begin
          m_rd++;
        end
      end
      if (!was_active && any_acc) m_active = 1;
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) m_cnt[r] = 0;
    m_rd = 0; m_active = 0; m_done = 0; m_ovf = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [ROWS-1:0] er;
    logic [DW-1:0]   ed;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int r = 0; r < ROWS; r++) er[r] = m_rdy(r);
        chk("ready", DW'(tile_in_ready), DW'(er));
        chk("valid", DW'(out_valid), DW'(m_valid()));
        chk("slice_done", DW'(slice_done), DW'(m_done));
        chk("overflow", DW'(overflow_err), DW'(m_ovf));
        if (m_valid()) begin
          for (int r = 0; r < ROWS; r++) ed[r*TW +: TW] = m_buf[r][m_rd];
          chk("data", out_data, ed);
          chk("tile_idx", DW'(out_tile_idx), DW'(m_rd));
          chk("last", DW'(out_last), DW'(m_rd == NT - 1));
        end
        if (slice_done === 1'b1) done_cnt++;
      end
    end
  end

  task automatic directed(input int mode, input int cyc);
    case (mode)
      1: begin
        if (cyc == 0) chk("s1_valid_c0", DW'(out_valid), DW'(0));
        if (cyc == 1) chk("s1_valid_c1", DW'(out_valid), DW'(1));
        if (cyc == 8) chk("s1_last_c8", DW'({out_last, out_tile_idx}), DW'(4'hF));
        if (cyc == 9) chk("s1_done_c9", DW'(slice_done), DW'(1));
      end
      2: begin
        if (cyc == 5) chk("s2_valid_c5", DW'(out_valid), DW'(0));
        if (cyc == 6) begin
          chk("s2_valid_c6", DW'(out_valid), DW'(1));
          chk("s2_row3_e0", DW'(out_data[3*TW +: 16]), DW'(16'h2300));
          chk("s2_row1_e7", DW'(out_data[TW+112 +: 16]), DW'(16'h2107));
        end
      end
      3: begin
        if (cyc == 7) chk("s3_ready_c7", DW'(tile_in_ready), DW'(4'hF));
        if (cyc == 8) chk("s3_ready_c8", DW'(tile_in_ready), DW'(4'h0));
        if (cyc == 12) chk("s3_ready_c12", DW'(tile_in_ready), DW'(4'h0));
        if (cyc == 14) begin
          chk("s3_ovf", DW'(overflow_err), DW'(1));
          chk("s3_idx_hold", DW'({out_valid, out_tile_idx}), DW'(4'h8));
          chk("s3_row0_e0", DW'(out_data[15:0]), DW'(16'h3000));
        end
        if (cyc == 19) chk("s3_row2_hold", DW'(out_data[2*TW +: 16]), DW'(16'h3200));
      end
      5: begin
        if (cyc == 0) chk("s5_ready_in_done", DW'(tile_in_ready), DW'(4'h0));
        if (cyc == 3) chk("s5_no_ovf", DW'(overflow_err), DW'(0));
      end
      7: begin
        if (cyc == 1) begin
          chk("s7_col0", DW'({out_valid, out_tile_idx}), DW'(4'h8));
          chk("s7_row0_e0", DW'(out_data[15:0]), DW'(16'h7000));
        end
      end
      default: ;
    endcase
  endtask

  // Drives one slice from the current negedge; returns at the negedge showing
  // slice_done or once stop_cols columns have been handed off.
  task automatic drive_slice(input int sl, input int lag3, input int hold,
                             input int extra_at, input int stop_cols, input int mode);
    int nxt [ROWS];
    bit vld [ROWS];
    bit rdy_prev [ROWS];
    int hs;
    bit fin;
    hs = 0;
    fin = 0;
    for (int r = 0; r < ROWS; r++) begin
      nxt[r] = 0; vld[r] = 0; rdy_prev[r] = 0;
    end
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      for (int r = 0; r < ROWS; r++) if (vld[r] && rdy_prev[r]) nxt[r]++;
      directed(mode, cyc);
      if ((cyc > 0 && slice_done === 1'b1) || hs >= stop_cols) begin
        fin = 1;
        tile_in_valid = '0;
      end else begin
        for (int r = 0; r < ROWS; r++) begin
          rdy_prev[r] = tile_in_ready[r];
          vld[r] = ((cyc >= ((r == 3) ? lag3 : 0)) && nxt[r] < NT) ||
                   (r == 0 && cyc == extra_at);
          tile_in_valid[r] = vld[r];
          tile_in_data[r*TW +: TW] = tile_val(sl, r, nxt[r]);
        end
        out_ready = (cyc >= hold);
        if (out_valid === 1'b1 && out_ready) hs++;
        @(negedge clk);
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout slice=%0d got=no_end want=end", sl);
      tile_in_valid = '0;
    end
  endtask

  task automatic idle(input int n);
    tile_in_valid = '0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tile_in_valid = '0;
    @(negedge clk);
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_ready", DW'(tile_in_ready), DW'(4'hF));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    tile_in_valid = '0;
    tile_in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("init_valid", DW'(out_valid), DW'(0));
    chk("init_ready", DW'(tile_in_ready), DW'(4'hF));
    chk("init_flags", DW'({slice_done, overflow_err}), DW'(0));
    rst_n = 1'b1;
    done_cnt = 0;

    drive_slice(1, 0, 0, -1, 99, 1);
    idle(3);
    chk("s1_done_pulses", DW'(done_cnt), DW'(1));

    drive_slice(2, 5, 0, -1, 99, 2);
    idle(2);

    drive_slice(3, 0, 20, 12, 99, 3);
    idle(2);
    pulse_reset();

    drive_slice(4, 0, 0, -1, 99, 4);
    drive_slice(5, 0, 0, -1, 99, 5);
    idle(3);

    drive_slice(6, 0, 0, -1, 3, 6);
    pulse_reset();
    drive_slice(7, 0, 0, -1, 99, 7);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
